// File: rtl/hcsr04_medidor.sv
// HC-SR04 ultrasonic ranger front end: fires the trigger, times the echo and delivers BCD centimetres.
// Build macro HCSR04_TIMEOUT_EN enables the echo wait timeout and the ESTOURO state.
module hcsr04_medidor #(
   parameter int TRIG_CYCLES   = 500,
   parameter int CYCLES_PER_CM = 2941,
   parameter int MAX_CM        = 400,
   parameter int ECHO_WAIT     = 1900000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        medir,
   input  logic        echo,
   output logic        trigger,
   output logic [11:0] medida,
   output logic        pronto,
   output logic        timeout,
   output logic [3:0]  db_estado
);

   typedef enum logic [3:0] {
      INICIAL     = 4'd0,
      PREPARA     = 4'd1,
      TRIGGER     = 4'd2,
      ESPERA_ECHO = 4'd3,
      MEDE        = 4'd4,
      ARMAZENA    = 4'd5,
      FINAL       = 4'd6,
      ESTOURO     = 4'd7
   } estado_t;

   localparam int TRIG_W = $clog2(TRIG_CYCLES + 1);
   localparam int TICK_W = $clog2(CYCLES_PER_CM + 1);
   localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CYCLES_PER_CM - 1);
   localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CYCLES_PER_CM / 2);
   localparam logic [11:0] MAX_BCD = {4'(MAX_CM / 100), 4'((MAX_CM / 10) % 10), 4'(MAX_CM % 10)};

   estado_t            estado;
   estado_t            prox_estado;
   logic [1:0]         echo_sync;
   logic               echo_s;
   logic [TRIG_W-1:0]  trig_cnt;
   logic [TICK_W-1:0]  tick;
   logic [11:0]        cm;
   logic               espera_estourou;

   assign echo_s    = echo_sync[1];
   assign db_estado = estado;

   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic [3:0] c;
      logic [3:0] d;
      logic [3:0] u;
      {c, d, u} = v;
      if (u != 4'd9) begin
         u = u + 4'd1;
      end else begin
         u = 4'd0;
         if (d != 4'd9) begin
            d = d + 4'd1;
         end else begin
            d = 4'd0;
            c = c + 4'd1;
         end
      end
      return {c, d, u};
   endfunction

   always_ff @(posedge clock) begin
      if (!reset) estado <= INICIAL;
      else        estado <= prox_estado;
   end

   always_comb begin
      prox_estado = INICIAL;
      case (estado)
         INICIAL:     prox_estado = medir ? PREPARA : INICIAL;
         PREPARA:     prox_estado = TRIGGER;
         TRIGGER:     prox_estado = (trig_cnt == TRIG_LAST) ? ESPERA_ECHO : TRIGGER;
         ESPERA_ECHO: begin
            if (echo_s)               prox_estado = MEDE;
            else if (espera_estourou) prox_estado = ESTOURO;
            else                      prox_estado = ESPERA_ECHO;
         end
         MEDE: begin
            if (!echo_s)              prox_estado = ARMAZENA;
            else if (espera_estourou) prox_estado = ESTOURO;
            else                      prox_estado = MEDE;
         end
         ARMAZENA:    prox_estado = FINAL;
         FINAL:       prox_estado = INICIAL;
         default:     prox_estado = INICIAL;
      endcase
   end

   always_comb begin
      trigger = (estado == TRIGGER);
      pronto  = (estado == FINAL) || (estado == ESTOURO);
`ifdef HCSR04_TIMEOUT_EN
      timeout = (estado == ESTOURO);
`else
      timeout = 1'b0;
`endif
   end

   // The first high echo_s cycle seen in ESPERA_ECHO is already part of the pulse width.
   always_ff @(posedge clock) begin
      if (!reset) begin
         echo_sync <= '0;
         trig_cnt  <= '0;
         tick      <= '0;
         cm        <= '0;
         medida    <= '0;
      end else begin
         echo_sync <= {echo_sync[0], echo};
         case (estado)
            PREPARA: begin
               cm       <= '0;
               tick     <= TICK_HALF;
               trig_cnt <= '0;
            end
            TRIGGER: trig_cnt <= trig_cnt + 1'b1;
            ESPERA_ECHO, MEDE: begin
               if (echo_s) begin
                  if (tick == TICK_LAST) begin
                     tick <= '0;
                     if (cm != MAX_BCD) cm <= bcd_inc(cm);
                  end else begin
                     tick <= tick + 1'b1;
                  end
               end
            end
            ARMAZENA: medida <= cm;
            default: ;
         endcase
      end
   end

`ifdef HCSR04_TIMEOUT_EN
   localparam int WAIT_W = $clog2(ECHO_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ECHO_WAIT - 1);
   logic [WAIT_W-1:0] wait_cnt;

   // Clearing on every state change gives a fresh count on entry to both waiting states.
   always_ff @(posedge clock) begin
      if (!reset)                                        wait_cnt <= '0;
      else if (estado != prox_estado)                    wait_cnt <= '0;
      else if (estado == ESPERA_ECHO || estado == MEDE)  wait_cnt <= wait_cnt + 1'b1;
   end

   assign espera_estourou = (wait_cnt == WAIT_LAST);
`else
   logic unused_echo_wait;
   assign unused_echo_wait = (ECHO_WAIT != 0);
   assign espera_estourou  = 1'b0;
`endif

endmodule
